// File: rtl/tx_mailbox_scheduler.sv
// Transmit mailbox scheduler: picks the highest-priority pending CAN mailbox, launches it
// when the bus is idle, and handles completion, lost arbitration, error retries and aborts.
module tx_mailbox_scheduler #(
   parameter int unsigned NUM_MB    = 4,
   parameter int unsigned MAX_RETRY = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_MB-1:0]      mbReq,
   input  logic [NUM_MB-1:0]      mbAbort,
   input  logic [NUM_MB*29-1:0]   mbId,
   input  logic [NUM_MB-1:0]      mbIde,
   input  logic                   busIdle,
   input  logic                   txDone,
   input  logic                   arbLost,
   input  logic                   txError,
   output logic                   txStart,
   output logic [2:0]             txSel,
   output logic [28:0]            txId,
   output logic                   txIde,
   output logic                   busy,
   output logic [NUM_MB-1:0]      pending,
   output logic [NUM_MB-1:0]      mbDone,
   output logic [NUM_MB-1:0]      mbFail
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SELECT   = 2'd1;
   localparam logic [1:0] S_WAIT_BUS = 2'd2;
   localparam logic [1:0] S_TX       = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [3:0]        retry_cnt, retry_nxt;
   logic [4:0]        retry_inc;
   logic              abort_pend, abort_pend_nxt;
   logic [NUM_MB-1:0] sel_dec, abort_hon, eligible, clr, done_nxt, fail_nxt;
   logic [29:0]       mb_key [NUM_MB];
   logic [29:0]       cur_key, best_key;
   logic              preempt, abort_sel, win_found, load_sel;
   logic [2:0]        win_idx;
   logic [28:0]       win_id;
   logic              win_ide;

   // Numerically lower key wins; a standard frame sorts before an extended one with the same base ID.
   function automatic logic [29:0] prio_key(input logic [28:0] id, input logic ide);
      return {id[28:18], ide, ide ? id[17:0] : 18'h0};
   endfunction

   assign cur_key   = prio_key(txId, txIde);
   assign busy      = (state == S_WAIT_BUS) || (state == S_TX);
   assign retry_inc = {1'b0, retry_cnt} + 5'd1;

   always_comb begin
      mb_key  = '{default: '0};
      sel_dec = '0;
      preempt = 1'b0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
         mb_key[i]  = prio_key(mbId[29*i +: 29], mbIde[i]);
         sel_dec[i] = (txSel == 3'(i));
         if (mbReq[i] && (mb_key[i] < cur_key))
            preempt = 1'b1;
      end
      abort_sel = |(mbAbort & sel_dec);
      // The in-flight mailbox cannot be aborted mid-frame; everything else is honoured at once.
      abort_hon = mbAbort & ~((state == S_TX) ? sel_dec : '0);
   end

   always_comb begin
      eligible  = pending & ~abort_hon;
      win_found = 1'b0;
      win_idx   = '0;
      best_key  = '1;
      win_id    = '0;
      win_ide   = 1'b0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
         if (eligible[i] && (!win_found || (mb_key[i] < best_key))) begin
            win_found = 1'b1;
            best_key  = mb_key[i];
            win_idx   = 3'(i);
            win_id    = mbId[29*i +: 29];
            win_ide   = mbIde[i];
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      retry_nxt      = retry_cnt;
      abort_pend_nxt = 1'b0;
      clr            = abort_hon;
      done_nxt       = '0;
      fail_nxt       = '0;
      load_sel       = 1'b0;
      txStart        = 1'b0;
      case (state)
         S_IDLE: begin
            if (|pending)
               state_nxt = S_SELECT;
         end
         S_SELECT: begin
            if (win_found) begin
               load_sel  = 1'b1;
               state_nxt = S_WAIT_BUS;
               if (win_idx != txSel)
                  retry_nxt = '0;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT_BUS: begin
            if (preempt || abort_sel) begin
               state_nxt = S_SELECT;
            end else if (busIdle) begin
               txStart   = 1'b1;
               state_nxt = S_TX;
            end
         end
         default: begin
            // An abort arriving together with the completion pulse counts as already latched.
            if (txDone) begin
               done_nxt  = sel_dec;
               clr       = clr | sel_dec;
               retry_nxt = '0;
               state_nxt = S_IDLE;
            end else if (txError) begin
               state_nxt = S_IDLE;
               if ((retry_inc >= 5'(MAX_RETRY)) || abort_pend || abort_sel) begin
                  fail_nxt  = sel_dec;
                  clr       = clr | sel_dec;
                  retry_nxt = '0;
               end else begin
                  retry_nxt = retry_inc[3:0];
               end
            end else if (arbLost) begin
               state_nxt = S_IDLE;
               if (abort_pend || abort_sel)
                  clr = clr | sel_dec;
            end else begin
               abort_pend_nxt = abort_pend | abort_sel;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         retry_cnt  <= '0;
         abort_pend <= 1'b0;
         pending    <= '0;
         mbDone     <= '0;
         mbFail     <= '0;
         txSel      <= '0;
         txId       <= '0;
         txIde      <= 1'b0;
      end else begin
         state      <= state_nxt;
         retry_cnt  <= retry_nxt;
         abort_pend <= abort_pend_nxt;
         pending    <= (pending & ~clr) | mbReq;
         mbDone     <= done_nxt;
         mbFail     <= fail_nxt;
         if (load_sel) begin
            txSel <= win_idx;
            txId  <= win_id;
            txIde <= win_ide;
         end
      end
   end

endmodule
